// File: rtl/acc_lut_pkg.sv
// Shared definitions for the writable accumulator-constant LUT and its loader.
package acc_lut_pkg;

  localparam int unsigned KEY_W = 5;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned ACC_LUT_DEPTH = 2 ** KEY_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  // Standard constants: keys 0-3 are meaningful, the rest default to zero.
  localparam logic [VAL_W-1:0] ACC_LUT_RESET [ACC_LUT_DEPTH] = '{
    0: 8'hFF,
    1: 8'h3F,
    2: 8'h00,
    3: 8'h01,
    default: 8'h00
  };

  // Reset value for an entry; indices past the standard table read as zero.
  function automatic logic [VAL_W-1:0] acc_lut_reset_val(input int unsigned idx);
    logic [VAL_W-1:0] val;
    val = '0;
    if (idx < ACC_LUT_DEPTH) begin
      val = ACC_LUT_RESET[idx[KEY_W-1:0]];
    end
    return val;
  endfunction

endpackage

// File: rtl/acc_lut_mem.sv
// Register-array LUT storage: one synchronous write port, one combinational
// read port, asynchronously reset to the standard constants.
module acc_lut_mem #(
  parameter int unsigned KEY_W = acc_lut_pkg::KEY_W,
  parameter int unsigned VAL_W = acc_lut_pkg::VAL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [KEY_W-1:0] waddr,
  input  logic [VAL_W-1:0] wdata,
  input  logic [KEY_W-1:0] raddr,
  output logic [VAL_W-1:0] rdata
);
  import acc_lut_pkg::*;

  localparam int unsigned DEPTH = 2 ** KEY_W;

  logic [VAL_W-1:0] mem_q [DEPTH];
  logic [VAL_W-1:0] mem_d [DEPTH];

  // Next-state of the array: at most one entry changes per cycle.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage flops; reset restores the full standard table, not partial loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= VAL_W'(acc_lut_reset_val(i));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/acc_lut_loader.sv
// Writable accumulator-constant LUT: byte-stream loader FSM plus gated
// combinational read port for the datapath.
module acc_lut_loader #(
  parameter int unsigned KEY_W = acc_lut_pkg::KEY_W,
  parameter int unsigned VAL_W = acc_lut_pkg::VAL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             load_abort,
  input  logic             in_valid,
  input  logic [VAL_W-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [KEY_W:0]   load_count,
  input  logic             acc_lut_en,
  input  logic [KEY_W-1:0] key,
  output logic [VAL_W-1:0] value
);
  import acc_lut_pkg::*;

  localparam logic [KEY_W-1:0] PTR_LAST = '1;

  loader_state_t    state_q, state_d;
  logic [KEY_W-1:0] ptr_q, ptr_d;
  logic [KEY_W:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             hs;
  logic             wr_en;
  logic [VAL_W-1:0] rd_val;

  // An abort in the same cycle as a handshake drops the byte.
  assign hs    = in_valid & ready_q;
  assign wr_en = hs & ~load_abort;

  // Loader next-state; busy/in_ready are registered copies of "in LOAD".
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (load_start && !load_abort) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (load_abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b0;
        end else if (hs) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Loader state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  acc_lut_mem #(
    .KEY_W(KEY_W),
    .VAL_W(VAL_W)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (wr_en),
    .waddr(ptr_q),
    .wdata(in_data),
    .raddr(key),
    .rdata(rd_val)
  );

  // Read port is blanked while a load is rewriting the table.
  always_comb begin
    value = '0;
    if (acc_lut_en && (state_q != LOAD)) begin
      value = rd_val;
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_count = cnt_q;

endmodule

// File: tb/tb_acc_lut_loader.sv
// Self-checking bench for acc_lut_loader.
module tb_acc_lut_loader;

  logic       clk;
  logic       reset;
  logic       load_start;
  logic       load_abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [5:0] load_count;
  logic       acc_lut_en;
  logic [4:0] key;
  logic [7:0] value;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic       en;
    logic [4:0] key;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t    reset_vecs [6];
  rd_vec_t    load_vecs  [2];
  logic [7:0] sb [$];
  logic [7:0] model [32];

  acc_lut_loader #(
    .KEY_W(5),
    .VAL_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .load_abort(load_abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .load_count(load_count),
    .acc_lut_en(acc_lut_en),
    .key       (key),
    .value     (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    model[0] = 8'hFF;
    model[1] = 8'h3F;
    model[3] = 8'h01;
  endtask

  // Drive a read, queue its expectation, compare when sampled.
  task automatic do_read(input logic en, input logic [4:0] k, input logic [7:0] exp, input string nm);
    logic [7:0] e;
    acc_lut_en = en;
    key        = k;
    sb.push_back(exp);
    @(negedge clk);
    e = sb.pop_front();
    chk(nm, 32'(value), 32'(e));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  int unsigned ready_cycles;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    load_start = 1'b0;
    load_abort = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    acc_lut_en = 1'b0;
    key        = 5'd0;
    model_reset();

    reset_vecs = '{
      '{1'b1, 5'd0,  8'hFF},
      '{1'b1, 5'd1,  8'h3F},
      '{1'b1, 5'd2,  8'h00},
      '{1'b1, 5'd3,  8'h01},
      '{1'b1, 5'd31, 8'h00},
      '{1'b0, 5'd0,  8'h00}
    };
    load_vecs = '{
      '{1'b1, 5'd5,  8'h85},
      '{1'b1, 5'd31, 8'h9F}
    };

    // Reset state
    #1;
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ready", 32'(in_ready),   32'd0);
    chk("rst_done",  32'(done),       32'd0);
    chk("rst_count", 32'(load_count), 32'd0);
    #11;
    reset = 1'b0;
    tick();

    foreach (reset_vecs[i]) do_read(reset_vecs[i].en, reset_vecs[i].key, reset_vecs[i].exp, "reset_table");

    // Full back-to-back load, with gated read and ignored load_start mid-load
    start_load();
    ready_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid   = 1'b1;
      in_data    = 8'(8'h80 + i);
      load_start = (i == 16);
      acc_lut_en = 1'b1;
      key        = 5'd0;
      @(negedge clk);
      if (in_ready) ready_cycles++;
      if (i == 0) chk("read_gated_in_load", 32'(value), 32'd0);
      if (i == 0 || i == 17 || i == 31) chk("count_during_load", 32'(load_count), 32'(i));
      model[i] = 8'(8'h80 + i);
      tick();
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    @(negedge clk);
    chk("full_ready_cycles", 32'(ready_cycles), 32'd32);
    chk("full_done",  32'(done),       32'd1);
    chk("full_busy",  32'(busy),       32'd0);
    chk("full_ready", 32'(in_ready),   32'd0);
    chk("full_count", 32'(load_count), 32'd32);
    foreach (load_vecs[i]) do_read(load_vecs[i].en, load_vecs[i].key, load_vecs[i].exp, "full_table");

    // Load with in_valid toggling; idle cycles carry garbage data
    start_load();
    chk("toggle_done_cleared", 32'(done), 32'd0);
    for (int c = 0; c < 64; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = (c % 2 == 0) ? 8'(8'h40 + c / 2) : 8'($urandom);
      @(negedge clk);
      if (c == 62) begin
        chk("toggle_busy_before_last", 32'(busy),       32'd1);
        chk("toggle_count_before_last", 32'(load_count), 32'd31);
      end
      if (c == 63) begin
        chk("toggle_done", 32'(done),       32'd1);
        chk("toggle_count", 32'(load_count), 32'd32);
      end
      if (c % 2 == 0) model[c / 2] = 8'(8'h40 + c / 2);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 32; k++) do_read(1'b1, 5'(k), model[k], "toggle_table");

    // Abort after 10 bytes with an 11th offered in the abort cycle
    start_load();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      model[i] = 8'(8'hA0 + i);
      tick();
    end
    in_data    = 8'hAA;
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_ready", 32'(in_ready),   32'd0);
    chk("abort_done",  32'(done),       32'd0);
    chk("abort_count", 32'(load_count), 32'd10);
    do_read(1'b1, 5'd9,  model[9],  "abort_key9_new");
    do_read(1'b1, 5'd10, model[10], "abort_key10_old");

    // in_valid while not ready is ignored
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid_count", 32'(load_count), 32'd10);
    chk("idle_valid_busy",  32'(busy),       32'd0);
    do_read(1'b1, 5'd0, model[0], "idle_valid_table");

    // load_start and load_abort together in IDLE: stay idle
    load_start = 1'b1;
    load_abort = 1'b1;
    tick();
    load_start = 1'b0;
    load_abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy",  32'(busy),     32'd0);
    chk("start_abort_ready", 32'(in_ready), 32'd0);

    // Reset after 20 bytes of a new load
    start_load();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + i);
      tick();
    end
    reset = 1'b1;
    #1;
    chk("midrst_busy",  32'(busy),       32'd0);
    chk("midrst_ready", 32'(in_ready),   32'd0);
    chk("midrst_count", 32'(load_count), 32'd0);
    model_reset();
    do_read(1'b1, 5'd0, 8'hFF, "midrst_key0");
    do_read(1'b1, 5'd4, 8'h00, "midrst_key4");
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    do_read(1'b1, 5'd3,  model[3],  "postrst_key3");
    do_read(1'b1, 5'd19, model[19], "postrst_key19");
    chk("postrst_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
